// File: rtl/k2_program_loader.sv
// Instruction-memory writer for the K2 core: loads a framed byte stream and holds the core in reset until done.
// Optional K2_LOADER_CSUM_EN adds a trailing checksum byte that must match the data sum before the core runs.
module k2_program_loader #(
    parameter int Bits     = 8,
    parameter int AddrBits = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic                in_valid,
    input  logic [Bits-1:0]     in_data,
    output logic                in_ready,
    input  logic [AddrBits-1:0] pc,
    output logic [Bits-1:0]     instr,
    output logic                core_rst_n,
    output logic                busy,
    output logic                done,
    output logic                err,
    output logic [AddrBits:0]   loaded_len
);

    localparam int unsigned         DEPTH   = 1 << AddrBits;
    localparam logic [Bits:0]       MAX_LEN = (Bits+1)'(DEPTH);
    localparam logic [AddrBits:0]   CNT_ONE = (AddrBits+1)'(1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LEN   = 3'd1,
        S_DATA  = 3'd2,
        S_CSUM  = 3'd3,
        S_RUN   = 3'd4,
        S_ERROR = 3'd5
    } state_t;

    state_t              state_q, state_d;
    logic [Bits-1:0]     mem_q [DEPTH];
    logic [AddrBits:0]   len_q, len_d;
    logic [AddrBits:0]   cnt_q, cnt_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                err_q, err_d;
    logic                core_rst_n_q, core_rst_n_d;
    logic                mem_we;
    logic                accept;
    logic                len_ok;
    logic [AddrBits:0]   cnt_next;
`ifdef K2_LOADER_CSUM_EN
    logic [Bits-1:0]     sum_q, sum_d;
`endif

    // Only the three load states accept bytes, and busy_q is exactly that decode.
    assign accept   = in_valid && busy_q;
    assign len_ok   = (in_data != '0) && ({1'b0, in_data} <= MAX_LEN);
    assign cnt_next = cnt_q + CNT_ONE;

    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        cnt_d   = cnt_q;
        mem_we  = 1'b0;
`ifdef K2_LOADER_CSUM_EN
        sum_d   = sum_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (start) state_d = S_LEN;
            end
            S_LEN: begin
                if (accept) begin
                    if (len_ok) begin
                        len_d   = in_data[AddrBits:0];
                        cnt_d   = '0;
`ifdef K2_LOADER_CSUM_EN
                        sum_d   = '0;
`endif
                        state_d = S_DATA;
                    end else begin
                        state_d = S_ERROR;
                    end
                end
            end
            S_DATA: begin
                if (accept) begin
                    mem_we = 1'b1;
                    cnt_d  = cnt_next;
`ifdef K2_LOADER_CSUM_EN
                    sum_d  = sum_q + in_data;
                    if (cnt_next == len_q) state_d = S_CSUM;
`else
                    if (cnt_next == len_q) state_d = S_RUN;
`endif
                end
            end
`ifdef K2_LOADER_CSUM_EN
            S_CSUM: begin
                if (accept) state_d = (in_data == sum_q) ? S_RUN : S_ERROR;
            end
`endif
            S_RUN, S_ERROR: begin
                if (start) state_d = S_LEN;
            end
            default: state_d = S_IDLE;
        endcase

        // Status flags are decoded from the next state so they change on the same edge as the FSM.
        busy_d       = (state_d == S_LEN) || (state_d == S_DATA) || (state_d == S_CSUM);
        done_d       = (state_d == S_RUN);
        err_d        = (state_d == S_ERROR);
        core_rst_n_d = (state_d == S_RUN);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            len_q        <= '0;
            cnt_q        <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
            core_rst_n_q <= 1'b0;
`ifdef K2_LOADER_CSUM_EN
            sum_q        <= '0;
`endif
        end else begin
            state_q      <= state_d;
            len_q        <= len_d;
            cnt_q        <= cnt_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            err_q        <= err_d;
            core_rst_n_q <= core_rst_n_d;
`ifdef K2_LOADER_CSUM_EN
            sum_q        <= sum_d;
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else if (mem_we) begin
            mem_q[cnt_q[AddrBits-1:0]] <= in_data;
        end
    end

    assign in_ready   = busy_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign err        = err_q;
    assign core_rst_n = core_rst_n_q;
    assign loaded_len = len_q;
    assign instr      = mem_q[pc];

endmodule

// File: tb/tb_k2_program_loader.sv
// Directed bench for k2_program_loader; covers both builds of K2_LOADER_CSUM_EN.
module tb_k2_program_loader;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       in_valid = 1'b0;
    logic [7:0] in_data = 8'h00;
    logic       in_ready;
    logic [3:0] pc = 4'h0;
    logic [7:0] instr;
    logic       core_rst_n;
    logic       busy;
    logic       done;
    logic       err;
    logic [4:0] loaded_len;

    int pass_cnt = 0;
    int total_cnt = 0;

    k2_program_loader #(.Bits(8), .AddrBits(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .pc         (pc),
        .instr      (instr),
        .core_rst_n (core_rst_n),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .loaded_len (loaded_len)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) begin
            pass_cnt++;
        end else begin
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick(1);
        start = 1'b0;
    endtask

    // Presents one byte and returns #1 after the edge that accepted it.
    task automatic send(input logic [7:0] b);
        int n;
        n = 0;
        in_valid = 1'b1;
        in_data  = b;
        while (!in_ready && n < 20) begin
            tick(1);
            n++;
        end
        check("send_ready", {31'b0, in_ready}, 32'd1);
        tick(1);
        in_valid = 1'b0;
        in_data  = 8'h00;
    endtask

    task automatic check_mem(input string tag, input int a, input logic [7:0] exp);
        pc = 4'(a);
        #1;
        check(tag, {24'b0, instr}, {24'b0, exp});
    endtask

    task automatic check_flags(input string tag, input logic b, input logic d, input logic e, input logic c);
        check({tag, "_busy"}, {31'b0, busy}, {31'b0, b});
        check({tag, "_ready"}, {31'b0, in_ready}, {31'b0, b});
        check({tag, "_done"}, {31'b0, done}, {31'b0, d});
        check({tag, "_err"}, {31'b0, err}, {31'b0, e});
        check({tag, "_core_rst_n"}, {31'b0, core_rst_n}, {31'b0, c});
    endtask

    initial begin
        // Reset state
        tick(3);
        rst_n = 1'b1;
        tick(1);
        check_flags("reset", 1'b0, 1'b0, 1'b0, 1'b0);
        check("reset_len", {27'b0, loaded_len}, 32'd0);
        for (int i = 0; i < 16; i++) check_mem("reset_mem", i, 8'h00);

        // Bytes offered in IDLE are not taken
        in_valid = 1'b1;
        in_data  = 8'h55;
        tick(2);
        check_flags("idle_offer", 1'b0, 1'b0, 1'b0, 1'b0);
        in_valid = 1'b0;

        // Good load: 3 bytes 1A 25 80, checksum BF
        pulse_start();
        check_flags("len_state", 1'b1, 1'b0, 1'b0, 1'b0);
        send(8'h03);
        check("good_len", {27'b0, loaded_len}, 32'd3);
        send(8'h1A);
        send(8'h25);
        check_flags("good_mid", 1'b1, 1'b0, 1'b0, 1'b0);
        send(8'h80);
`ifdef K2_LOADER_CSUM_EN
        check_flags("good_pre_csum", 1'b1, 1'b0, 1'b0, 1'b0);
        send(8'hBF);
`endif
        check_flags("good_run", 1'b0, 1'b1, 1'b0, 1'b1);
        check_mem("good_mem0", 0, 8'h1A);
        check_mem("good_mem1", 1, 8'h25);
        check_mem("good_mem2", 2, 8'h80);
        check_mem("good_mem3", 3, 8'h00);

        // Restart from RUN drops core reset on the same edge; then an oversized length
        pulse_start();
        check_flags("restart_run", 1'b1, 1'b0, 1'b0, 1'b0);
        send(8'h11);
        check_flags("len_too_big", 1'b0, 1'b0, 1'b1, 1'b0);
        check("len_too_big_len", {27'b0, loaded_len}, 32'd3);
        check_mem("len_too_big_mem0", 0, 8'h1A);

`ifdef K2_LOADER_CSUM_EN
        // Bad checksum
        pulse_start();
        send(8'h03);
        send(8'h1A);
        send(8'h25);
        send(8'h80);
        send(8'h00);
        check_flags("bad_csum", 1'b0, 1'b0, 1'b1, 1'b0);
`endif

        // Restart from ERROR clears err; zero length errors again
        pulse_start();
        check_flags("restart_err", 1'b1, 1'b0, 1'b0, 1'b0);
        send(8'h00);
        check_flags("len_zero", 1'b0, 1'b0, 1'b1, 1'b0);
        check_mem("len_zero_mem1", 1, 8'h25);
        check_mem("len_zero_mem2", 2, 8'h80);

        // Full-depth length is legal; here 4 bytes with valid gaps and an ignored start
        pulse_start();
        send(8'h04);
        send(8'h01);
        tick(2);
        check_flags("gap_a", 1'b1, 1'b0, 1'b0, 1'b0);
        send(8'h02);
        start = 1'b1;
        tick(1);
        start = 1'b0;
        tick(2);
        check_flags("gap_start", 1'b1, 1'b0, 1'b0, 1'b0);
        check("gap_start_len", {27'b0, loaded_len}, 32'd4);
        send(8'h03);
        tick(1);
        check_flags("gap_c", 1'b1, 1'b0, 1'b0, 1'b0);
        send(8'h04);
`ifdef K2_LOADER_CSUM_EN
        send(8'h0A);
`endif
        check_flags("gap_run", 1'b0, 1'b1, 1'b0, 1'b1);
        check("gap_len", {27'b0, loaded_len}, 32'd4);
        check_mem("gap_mem0", 0, 8'h01);
        check_mem("gap_mem1", 1, 8'h02);
        check_mem("gap_mem2", 2, 8'h03);
        check_mem("gap_mem3", 3, 8'h04);
        check_mem("gap_mem4", 4, 8'h00);

        // Shorter program leaves the tail of memory intact
        pulse_start();
        send(8'h01);
        send(8'h99);
`ifdef K2_LOADER_CSUM_EN
        send(8'h99);
`endif
        check_flags("short_run", 1'b0, 1'b1, 1'b0, 1'b1);
        check("short_len", {27'b0, loaded_len}, 32'd1);
        check_mem("short_mem0", 0, 8'h99);
        check_mem("short_mem1", 1, 8'h02);
        check_mem("short_mem3", 3, 8'h04);

        // Length 16 fills the whole memory
        pulse_start();
        send(8'h10);
        for (int i = 0; i < 16; i++) send(8'(8'hF0 + i));
`ifdef K2_LOADER_CSUM_EN
        send(8'h78);
`endif
        check_flags("full_run", 1'b0, 1'b1, 1'b0, 1'b1);
        check("full_len", {27'b0, loaded_len}, 32'd16);
        check_mem("full_mem0", 0, 8'hF0);
        check_mem("full_mem15", 15, 8'hFF);

        // Async reset mid-DATA after 2 of 3 bytes
        pulse_start();
        send(8'h03);
        send(8'hAA);
        send(8'hBB);
        rst_n = 1'b0;
        #1;
        check_flags("mid_reset", 1'b0, 1'b0, 1'b0, 1'b0);
        check("mid_reset_len", {27'b0, loaded_len}, 32'd0);
        for (int i = 0; i < 16; i++) check_mem("mid_reset_mem", i, 8'h00);
        tick(2);
        rst_n = 1'b1;
        tick(1);

        // Two-byte program
        pulse_start();
        send(8'h02);
        send(8'h11);
        check_flags("two_mid", 1'b1, 1'b0, 1'b0, 1'b0);
        send(8'h22);
`ifdef K2_LOADER_CSUM_EN
        send(8'h33);
`endif
        check_flags("two_run", 1'b0, 1'b1, 1'b0, 1'b1);
        check_mem("two_mem0", 0, 8'h11);
        check_mem("two_mem1", 1, 8'h22);
        check_mem("two_mem2", 2, 8'h00);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/k2_program_loader.md
Name: k2_program_loader

Overview:
- Writer side of the K2 instruction-memory interface. The core only fetches from this memory; this block owns it.
- Accepts a framed byte stream over a valid/ready handshake: length byte, N instruction bytes, then a checksum byte.
- Writes the instruction bytes into a local instruction memory and serves combinational fetches to the core by PC.
- Holds the core in reset until a complete, verified program is loaded, then releases it.

Parameters:
Bits, 8, instruction/byte width
AddrBits, 4, instruction memory address width (depth = 2**AddrBits)

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  begin a load (sampled in IDLE/RUN/ERROR only)
in_valid  input  1  stream byte valid
in_data  input  Bits  stream byte
in_ready  output  1  loader can accept a byte
pc  input  AddrBits  core fetch address
instr  output  Bits  instruction at pc (combinational read)
core_rst_n  output  1  active-low reset to the K2 core
busy  output  1  load in progress (LEN/DATA/CSUM)
done  output  1  program loaded and running (RUN)
err  output  1  load failed (ERROR)
loaded_len  output  AddrBits+1  accepted program length

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; all memory words=0; loaded_len=0; internal address and checksum=0.
  - Outputs: core_rst_n=0, in_ready=0, busy=0, done=0, err=0.
- Transfer rule: a byte is accepted on a rising edge with in_valid && in_ready. in_ready is registered-state decoded: 1 in LEN/DATA/CSUM, 0 elsewhere.
- FSM:
  - IDLE: core_rst_n=0. start=1 -> LEN.
  - LEN: on accept, L=in_data.
    - L==0 or L>2**AddrBits -> ERROR.
    - Otherwise loaded_len=L, addr=0, sum=0 -> DATA.
  - DATA: on accept, mem[addr]=in_data, sum=sum+in_data (mod 2**Bits), addr++.
    - After the L-th byte -> CSUM.
  - CSUM: on accept, in_data==sum -> RUN; otherwise -> ERROR.
  - RUN: done=1; core_rst_n=1 from the edge that accepted the checksum, so the core leaves reset the cycle after the last handshake. start=1 -> LEN, with core_rst_n=0 from that same edge.
  - ERROR: err=1, core_rst_n=0. start=1 -> LEN, with err cleared on that edge.
- start in LEN/DATA/CSUM is ignored. A load cannot be aborted except by rst_n.
- core_rst_n, busy, done and err are registered and update on the same edge as the state change.
- Memory words not rewritten by a shorter program keep their previous contents. instr=mem[pc] for any pc, including pc>=loaded_len.
- The length byte is excluded from the checksum. The checksum wraps modulo 2**Bits.
- When rst_n is asserted mid-load, the block returns to IDLE and clears memory immediately; no partial state is retained.
- in_data is ignored whenever in_ready=0.

Optional Feature:
- Macro K2_LOADER_CSUM_EN.
- Defined: the CSUM state exists as described above.
- Undefined: the CSUM state and checksum register are removed; after the L-th data byte, DATA -> RUN directly and core_rst_n rises on that edge. err can then only come from an illegal length.

Test Plan:
- Reset: apply rst_n=0 then release -> core_rst_n=0, in_ready=0, busy=done=err=0, instr=0x00 for pc 0..15.
- Good load: start, then stream 0x03, 0x1A, 0x25, 0x80, 0xBF -> RUN, done=1, core_rst_n=1 the cycle after 0xBF is accepted, loaded_len=3, instr at pc0/1/2 = 0x1A/0x25/0x80.
- Bad checksum: same stream with final byte 0x00 -> ERROR, err=1, core_rst_n=0; then start -> LEN, err=0, in_ready=1.
- Illegal length: length byte 0x11, and separately 0x00 -> ERROR right after the length handshake, memory unchanged.
- Backpressure and ignores: in_valid gaps of 1-3 cycles mid-DATA plus a start pulse during DATA -> same final memory and timing per accepted byte, start has no effect. Bytes presented in IDLE are not accepted.
- Reset mid-DATA after 2 of 3 bytes -> IDLE, all memory 0, core_rst_n=0. Without K2_LOADER_CSUM_EN, stream 0x02, 0x11, 0x22 -> RUN after 0x22, instr pc0/1 = 0x11/0x22.
